// File: rtl/ysyx_23060124_axil_sram_pkg.sv
// Shared constants, response codes and FSM encodings for the AXI4-Lite SRAM responder.
package ysyx_23060124_axil_sram_pkg;

    localparam int          ISA_WIDTH      = 32;
    localparam int          ISA_ADDR_WIDTH = 32;
    localparam logic [31:0] RESET_PC       = 32'h8000_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    function automatic logic [1:0] resp_for(input logic in_range);
        return in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    endfunction

endpackage

// File: rtl/ysyx_23060124_sram_array.sv
// Word array with one byte-strobed synchronous write port and one combinational read port.
module ysyx_23060124_sram_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Read is combinational so a same-edge commit is not visible until the next cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_23060124_axil_sram.sv
// AXI4-Lite responder over a word SRAM; independent read/write FSMs with programmable latency.
module ysyx_23060124_axil_sram
    import ysyx_23060124_axil_sram_pkg::*;
#(
    parameter int                DATA_W      = ISA_WIDTH,
    parameter int                ADDR_W      = ISA_ADDR_WIDTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = RESET_PC,
    parameter int                DEPTH_WORDS = 4096,
    parameter int                RD_LAT      = 1,
    parameter int                WR_LAT      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
    input  logic                S_AXI_AWVALID,
    output logic                S_AXI_AWREADY,
    input  logic [DATA_W-1:0]   S_AXI_WDATA,
    input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
    input  logic                S_AXI_WVALID,
    output logic                S_AXI_WREADY,
    output logic [1:0]          S_AXI_BRESP,
    output logic                S_AXI_BVALID,
    input  logic                S_AXI_BREADY,
    input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
    input  logic                S_AXI_ARVALID,
    output logic                S_AXI_ARREADY,
    output logic [DATA_W-1:0]   S_AXI_RDATA,
    output logic [1:0]          S_AXI_RRESP,
    output logic                S_AXI_RVALID,
    input  logic                S_AXI_RREADY
);

    localparam int                STRB_W = DATA_W / 8;
    localparam int                IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH_WORDS);

    // ---------------- read side ----------------
    rd_state_e         r_state_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [3:0]        r_cnt_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;

    logic [ADDR_W-1:0] rd_off;
    logic              rd_in_range;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_word;

    assign rd_off      = araddr_q - BASE_ADDR;
    assign rd_in_range = (araddr_q >= BASE_ADDR) && (rd_off < SPAN);
    assign rd_idx      = rd_off[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= AXI_RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (S_AXI_ARVALID && arready_q) begin
                        araddr_q  <= S_AXI_ARADDR;
                        r_cnt_q   <= 4'(RD_LAT - 1);
                        arready_q <= 1'b0;
                        r_state_q <= R_WAIT;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q != 4'd0) begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end else begin
                        rdata_q   <= rd_in_range ? rd_word : '0;
                        rresp_q   <= resp_for(rd_in_range);
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    // ---------------- write side ----------------
    wr_state_e         w_state_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_got_q;
    logic              w_got_q;
    logic [3:0]        w_cnt_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;

    logic              aw_hs;
    logic              w_hs;
    logic              aw_have;
    logic              w_have;
    logic [ADDR_W-1:0] wr_off;
    logic              wr_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_commit;

    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign aw_have     = aw_got_q || aw_hs;
    assign w_have      = w_got_q || w_hs;
    assign wr_off      = awaddr_q - BASE_ADDR;
    assign wr_in_range = (awaddr_q >= BASE_ADDR) && (wr_off < SPAN);
    assign wr_idx      = wr_off[IDX_W+1:2];
    // Reset forces W_IDLE asynchronously, so an abandoned write can never reach commit.
    assign wr_commit   = (w_state_q == W_WAIT) && (w_cnt_q == 4'd0) && wr_in_range;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_q <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= AXI_RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q <= S_AXI_AWADDR;
                        aw_got_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q <= S_AXI_WDATA;
                        wstrb_q <= S_AXI_WSTRB;
                        w_got_q <= 1'b1;
                    end
                    awready_q <= !aw_have;
                    wready_q  <= !w_have;
                    if (aw_have && w_have) begin
                        aw_got_q  <= 1'b0;
                        w_got_q   <= 1'b0;
                        w_cnt_q   <= 4'(WR_LAT - 1);
                        w_state_q <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q != 4'd0) begin
                        w_cnt_q <= w_cnt_q - 4'd1;
                    end else begin
                        bresp_q   <= resp_for(wr_in_range);
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    ysyx_23060124_sram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_commit),
        .waddr_i (wr_idx),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .raddr_i (rd_idx),
        .rdata_o (rd_word)
    );

    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;

endmodule
